// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pkg
//  Description : Shared Gray/binary conversion functions and limit constants
//                for the Gray-code counter family.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_pkg;

    localparam int MAX_WIDTH = 16;

    localparam logic [MAX_WIDTH-1:0] c_ALL_ONES = '1;
    localparam logic [MAX_WIDTH-1:0] c_ZERO     = '0;

    // Callers zero-extend narrower values; leading zeros convert to zeros.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_conv.sv
`default_nettype none
// ============================================================================
//  Module      : gray_conv
//  Description : Combinational binary->Gray and Gray->binary converter pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray_out,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    assign gray_out = WIDTH'(bin2gray(MAX_WIDTH'(bin_in)));
    assign bin_out  = WIDTH'(gray2bin(MAX_WIDTH'(gray_in)));

endmodule
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Registered up/down Gray counter with load, wrap/saturate
//                limits and a matching binary view of the same state.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(c_ALL_ONES);
    localparam logic [WIDTH-1:0] c_MIN = WIDTH'(c_ZERO);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_at_limit;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic [WIDTH-1:0] w_load_bin;
    logic             w_wrap_next;
    logic             w_at_limit_next;

    // One converter serves both the next-state Gray encode and the load decode.
    gray_conv #(
        .WIDTH (WIDTH)
    ) u_conv (
        .bin_in   (w_bin_next),
        .gray_out (w_gray_next),
        .gray_in  (load_gray),
        .bin_out  (w_load_bin)
    );

    always_comb begin
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (load) begin
            w_bin_next = w_load_bin;
        end else if (en) begin
            if (up) begin
                if (r_bin != c_MAX) begin
                    w_bin_next = r_bin + 1'b1;
                end else if (!SATURATE) begin
                    w_bin_next  = c_MIN;
                    w_wrap_next = 1'b1;
                end
            end else begin
                if (r_bin != c_MIN) begin
                    w_bin_next = r_bin - 1'b1;
                end else if (!SATURATE) begin
                    w_bin_next  = c_MAX;
                    w_wrap_next = 1'b1;
                end
            end
        end
        w_at_limit_next = up ? (w_bin_next == c_MAX) : (w_bin_next == c_MIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin      <= c_MIN;
            r_gray     <= c_MIN;
            r_wrap     <= 1'b0;
            r_at_limit <= 1'b0;
        end else begin
            r_bin      <= w_bin_next;
            r_gray     <= w_gray_next;
            r_wrap     <= w_wrap_next;
            r_at_limit <= w_at_limit_next;
        end
    end

    assign bin_q    = r_bin;
    assign gray_q   = r_gray;
    assign wrap     = r_wrap;
    assign at_limit = r_at_limit;

endmodule
`default_nettype wire
